// File: rtl/cache_ctrl.sv
// Direct-mapped write-back cache controller: drives the tag/data array pins,
// writes back dirty victims and refills lines from memory before retrying the access.
module cache_ctrl #(
  parameter int DATA_W   = 16,
  parameter int TAG_W    = 5,
  parameter int INDEX_W  = 4,
  parameter int OFFSET_W = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                cpu_req,
  input  logic                                cpu_we,
  input  logic [TAG_W+INDEX_W+OFFSET_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]                   cpu_wdata,
  output logic                                cpu_ready,
  output logic                                cpu_done,
  output logic [DATA_W-1:0]                   cpu_rdata,
  output logic                                cpu_miss,
  output logic                                c_enable,
  output logic                                c_cmp,
  output logic                                c_write,
  output logic                                c_valid_in,
  output logic [INDEX_W-1:0]                  c_index,
  output logic [OFFSET_W-1:0]                 c_word,
  output logic [TAG_W-1:0]                    c_tag,
  output logic [DATA_W-1:0]                   c_data_in,
  input  logic                                c_hit,
  input  logic                                c_dirty,
  input  logic                                c_valid,
  input  logic [TAG_W-1:0]                    c_tag_out,
  input  logic [DATA_W-1:0]                   c_data_out,
  output logic                                mem_req,
  output logic                                mem_we,
  output logic [TAG_W+INDEX_W+OFFSET_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]                   mem_wdata,
  input  logic [DATA_W-1:0]                   mem_rdata,
  input  logic                                mem_ack
);
  localparam int ADDR_W = TAG_W + INDEX_W + OFFSET_W;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPARE = 2'd1;
  localparam logic [1:0] S_WB      = 2'd2;
  localparam logic [1:0] S_FILL    = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [OFFSET_W-1:0] cnt_q, cnt_d;
  logic                req_we_q, req_we_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
  logic                miss_flag_q, miss_flag_d;
  logic                cpu_done_q, cpu_done_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                cpu_miss_q, cpu_miss_d;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_index;
  logic [OFFSET_W-1:0] req_word;
  logic                cnt_last;

  assign req_tag   = req_addr_q[ADDR_W-1 -: TAG_W];
  assign req_index = req_addr_q[OFFSET_W +: INDEX_W];
  assign req_word  = req_addr_q[OFFSET_W-1:0];
  assign cnt_last  = (cnt_q == {OFFSET_W{1'b1}});

  // CPU side: a request is taken on any edge where cpu_req & cpu_ready; the
  // matching cpu_done pulses for one cycle later. Memory side: a beat completes
  // on every edge where mem_req & mem_ack, with request fields held until then.
  assign cpu_ready = (state_q == S_IDLE);
  assign cpu_done  = cpu_done_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_miss  = cpu_miss_q;

  always_comb begin
    c_enable   = 1'b0;
    c_cmp      = 1'b0;
    c_write    = 1'b0;
    c_valid_in = 1'b0;
    c_index    = '0;
    c_word     = '0;
    c_tag      = '0;
    c_data_in  = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      S_COMPARE: begin
        c_enable  = 1'b1;
        c_cmp     = 1'b1;
        c_write   = req_we_q;
        c_index   = req_index;
        c_word    = req_word;
        c_tag     = req_tag;
        c_data_in = req_wdata_q;
      end
      S_WB: begin
        c_enable  = 1'b1;
        c_index   = req_index;
        c_word    = cnt_q;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {c_tag_out, req_index, cnt_q};
        mem_wdata = c_data_out;
      end
      S_FILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_index, cnt_q};
        // Only the final beat marks the line valid, so a torn fill stays invalid.
        if (mem_ack) begin
          c_enable   = 1'b1;
          c_write    = 1'b1;
          c_index    = req_index;
          c_word     = cnt_q;
          c_tag      = req_tag;
          c_data_in  = mem_rdata;
          c_valid_in = cnt_last;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    miss_flag_d = miss_flag_q;
    cpu_done_d  = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    cpu_miss_d  = cpu_miss_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          req_we_d    = cpu_we;
          req_addr_d  = cpu_addr;
          req_wdata_d = cpu_wdata;
          miss_flag_d = 1'b0;
          state_d     = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (c_hit) begin
          cpu_done_d = 1'b1;
          cpu_miss_d = miss_flag_q;
          if (!req_we_q) cpu_rdata_d = c_data_out;
          state_d = S_IDLE;
        end else begin
          miss_flag_d = 1'b1;
          cnt_d       = '0;
          state_d     = (c_valid && c_dirty) ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        if (mem_ack) begin
          cnt_d = cnt_q + OFFSET_W'(1);
          if (cnt_last) state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (mem_ack) begin
          cnt_d = cnt_q + OFFSET_W'(1);
          if (cnt_last) state_d = S_COMPARE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      miss_flag_q <= 1'b0;
      cpu_done_q  <= 1'b0;
      cpu_rdata_q <= '0;
      cpu_miss_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      miss_flag_q <= miss_flag_d;
      cpu_done_q  <= cpu_done_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_miss_q  <= cpu_miss_d;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: behavioural cache array and memory models, directed CPU
// accesses, and monitors that pop expected completions and memory beats from queues.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [10:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ready, cpu_done, cpu_miss;
  logic [15:0] cpu_rdata;
  logic        c_enable, c_cmp, c_write, c_valid_in;
  logic [3:0]  c_index;
  logic [1:0]  c_word;
  logic [4:0]  c_tag;
  logic [15:0] c_data_in;
  logic        c_hit, c_dirty, c_valid;
  logic [4:0]  c_tag_out;
  logic [15:0] c_data_out;
  logic        mem_req, mem_we, mem_ack;
  logic [10:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;

  logic [16:0] exp_q[$];
  logic [27:0] exp_beat_q[$];

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_miss(cpu_miss),
    .c_enable(c_enable), .c_cmp(c_cmp), .c_write(c_write), .c_valid_in(c_valid_in),
    .c_index(c_index), .c_word(c_word), .c_tag(c_tag), .c_data_in(c_data_in),
    .c_hit(c_hit), .c_dirty(c_dirty), .c_valid(c_valid), .c_tag_out(c_tag_out),
    .c_data_out(c_data_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // ---------------- cache array model ----------------
  logic [4:0]  tag_a   [16];
  logic        valid_a [16];
  logic        dirty_a [16];
  logic [15:0] data_a  [16][4];

  initial begin
    for (int i = 0; i < 16; i++) begin
      tag_a[i] = '0; valid_a[i] = 1'b0; dirty_a[i] = 1'b0;
      for (int w = 0; w < 4; w++) data_a[i][w] = '0;
    end
  end

  always_comb begin
    c_hit = 1'b0; c_dirty = 1'b0; c_valid = 1'b0; c_tag_out = '0; c_data_out = '0;
    if (c_enable) begin
      c_valid    = valid_a[c_index];
      c_dirty    = dirty_a[c_index];
      c_tag_out  = tag_a[c_index];
      c_data_out = data_a[c_index][c_word];
      if (c_cmp) c_hit = valid_a[c_index] && (tag_a[c_index] == c_tag);
    end
  end

  always @(posedge clk) begin
    if (c_enable && c_write) begin
      if (c_cmp) begin
        if (valid_a[c_index] && tag_a[c_index] == c_tag) begin
          data_a[c_index][c_word] <= c_data_in;
          dirty_a[c_index] <= 1'b1;
        end
      end else begin
        tag_a[c_index] <= c_tag;
        data_a[c_index][c_word] <= c_data_in;
        valid_a[c_index] <= c_valid_in;
        dirty_a[c_index] <= 1'b0;
      end
    end
  end

  // ---------------- memory model ----------------
  logic [15:0] mem [2048];
  int ack_delay = 0;
  int wait_cnt = 0;
  int beat_cnt = 0;

  initial for (int i = 0; i < 2048; i++) mem[i] = 16'hA000 + 16'(i % 4);

  assign mem_ack   = mem_req && (wait_cnt == ack_delay);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_req && mem_ack) begin
      wait_cnt <= 0;
      beat_cnt <= beat_cnt + 1;
      if (mem_we) mem[mem_addr] <= mem_wdata;
    end else if (mem_req) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [27:0] beat(input logic we, input logic [10:0] addr, input logic [15:0] d);
    return {we, addr, we ? d : 16'h0};
  endfunction

  task automatic push_beats(input logic we, input logic [10:0] base, input logic [15:0] d0,
                            input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] d3);
    exp_beat_q.push_back(beat(we, base,          d0));
    exp_beat_q.push_back(beat(we, base + 11'd1,  d1));
    exp_beat_q.push_back(beat(we, base + 11'd2,  d2));
    exp_beat_q.push_back(beat(we, base + 11'd3,  d3));
  endtask

  task automatic issue(input logic we, input logic [10:0] addr, input logic [15:0] wdata);
    @(negedge clk);
    check("ready_before_req", {31'b0, cpu_ready}, 32'd1);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(posedge clk);
    #1 cpu_req = 1'b0;
  endtask

  // Latency counts negedges after the accept edge until cpu_done is seen.
  task automatic cpu_access(input string name, input logic we, input logic [10:0] addr,
                            input logic [15:0] wdata, input int exp_lat);
    int cyc;
    bit seen;
    issue(we, addr, wdata);
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cpu_done) seen = 1'b1;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL %s_timeout: got no cpu_done in %0d cycles, expected done", name, cyc);
    end else check({name, "_latency"}, cyc, exp_lat);
  endtask

  // ---------------- monitors ----------------
  logic [27:0] cur_beat, pend_beat, exp_b;
  logic [16:0] exp_done;
  logic        pend_valid = 1'b0;

  assign cur_beat = {mem_we, mem_addr, mem_we ? mem_wdata : 16'h0};

  always @(negedge clk) begin
    if (!rst_n) pend_valid = 1'b0;
    else begin
      if (cpu_done) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL done_unexpected: got rdata 0x%0h miss %0b, expected no completion", cpu_rdata, cpu_miss);
        end else begin
          exp_done = exp_q.pop_front();
          check("done_rdata", {16'b0, cpu_rdata}, {16'b0, exp_done[15:0]});
          check("done_miss", {31'b0, cpu_miss}, {31'b0, exp_done[16]});
        end
      end
      if (pend_valid && mem_req) check("mem_stable", {4'b0, cur_beat}, {4'b0, pend_beat});
      if (mem_req && mem_ack) begin
        if (exp_beat_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL mem_beat_unexpected: got 0x%0h, expected no beat", cur_beat);
        end else begin
          exp_b = exp_beat_q.pop_front();
          check("mem_beat", {4'b0, cur_beat}, {4'b0, exp_b});
        end
      end
      pend_valid = mem_req && !mem_ack;
      pend_beat  = cur_beat;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int base;
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'b0, cpu_ready}, 32'd1);
    check("rst_done", {31'b0, cpu_done}, 32'd0);
    check("rst_rdata", {16'b0, cpu_rdata}, 32'd0);
    check("rst_miss", {31'b0, cpu_miss}, 32'd0);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_c_enable", {31'b0, c_enable}, 32'd0);

    // Cold read: line fill, retry hits.
    ack_delay = 0;
    push_beats(1'b0, 11'h740, 16'h0, 16'h0, 16'h0, 16'h0);
    exp_q.push_back({1'b1, 16'hA003});
    cpu_access("cold_read", 1'b0, 11'h743, 16'h0, 7);

    exp_q.push_back({1'b0, 16'hA003});
    cpu_access("hit_read", 1'b0, 11'h743, 16'h0, 2);

    exp_q.push_back({1'b0, 16'hA003});
    cpu_access("hit_write", 1'b1, 11'h741, 16'hBEEF, 2);
    exp_q.push_back({1'b0, 16'hBEEF});
    cpu_access("read_back", 1'b0, 11'h741, 16'h0, 2);

    // Conflict miss on dirty line: write-back then fill.
    push_beats(1'b1, 11'h740, 16'hA000, 16'hBEEF, 16'hA002, 16'hA003);
    push_beats(1'b0, 11'h0C0, 16'h0, 16'h0, 16'h0, 16'h0);
    exp_q.push_back({1'b1, 16'hA000});
    cpu_access("conflict_read", 1'b0, 11'h0C0, 16'h0, 11);

    // Slow memory: both phases stretched, fields held while waiting.
    exp_q.push_back({1'b0, 16'hA000});
    cpu_access("dirty_write", 1'b1, 11'h0C1, 16'h1234, 2);
    ack_delay = 3;
    push_beats(1'b1, 11'h0C0, 16'hA000, 16'h1234, 16'hA002, 16'hA003);
    push_beats(1'b0, 11'h740, 16'h0, 16'h0, 16'h0, 16'h0);
    exp_q.push_back({1'b1, 16'hA003});
    cpu_access("slow_mem_read", 1'b0, 11'h743, 16'h0, 35);

    // Reset after two fill beats.
    ack_delay = 0;
    base = beat_cnt;
    exp_beat_q.push_back(beat(1'b0, 11'h0C0, 16'h0));
    exp_beat_q.push_back(beat(1'b0, 11'h0C1, 16'h0));
    issue(1'b0, 11'h0C0, 16'h0);
    cyc = 0;
    while (beat_cnt < base + 2 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("beats_before_reset", beat_cnt - base, 32'd2);
    rst_n = 1'b0;
    #1;
    check("midrst_mem_req", {31'b0, mem_req}, 32'd0);
    check("midrst_c_enable", {31'b0, c_enable}, 32'd0);
    check("midrst_ready", {31'b0, cpu_ready}, 32'd1);
    check("midrst_rdata", {16'b0, cpu_rdata}, 32'd0);
    check("midrst_miss", {31'b0, cpu_miss}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    push_beats(1'b0, 11'h0C0, 16'h0, 16'h0, 16'h0, 16'h0);
    exp_q.push_back({1'b1, 16'hA000});
    cpu_access("refetch_after_reset", 1'b0, 11'h0C0, 16'h0, 7);
    exp_q.push_back({1'b0, 16'h1234});
    cpu_access("read_written_back", 1'b0, 11'h0C1, 16'h0, 2);

    repeat (5) @(negedge clk);
    check("done_queue_empty", exp_q.size(), 32'd0);
    check("beat_queue_empty", exp_beat_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Direct-mapped write-back cache controller sitting directly upstream of the `cache` array block.
- Accepts single-word CPU read/write requests and drives the array's enable/index/word/cmp/write/tag/data_in/valid_in pins.
- On a miss it writes back a dirty victim line, then fills the new line from backing memory over a req/ack handshake, and finally retries the access.
- 11-bit word address = {tag[4:0], index[3:0], word[1:0]}; 16-bit data; 4 words per line.

Parameters:
- DATA_W, 16, data word width
- TAG_W, 5, tag width
- INDEX_W, 4, line index width
- OFFSET_W, 2, word-in-line width (line = 2^OFFSET_W words)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  request valid
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  11  {tag,index,word}
- cpu_wdata  in  16  write data
- cpu_ready  out  1  controller idle, can accept
- cpu_done  out  1  one-cycle completion pulse
- cpu_rdata  out  16  read data, valid while cpu_done
- cpu_miss  out  1  qualifies cpu_done: access missed
- c_enable, c_cmp, c_write, c_valid_in  out  1 each  cache array controls
- c_index  out  4  cache array index
- c_word  out  2  cache array word
- c_tag  out  5  cache array tag
- c_data_in  out  16  cache array data_in
- c_hit, c_dirty, c_valid  in  1 each  cache array status
- c_tag_out  in  5  cache array tag_out
- c_data_out  in  16  cache array data_out
- mem_req, mem_we  out  1 each  memory request and direction
- mem_addr  out  11  memory word address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- mem_ack  in  1  beat completes in any cycle where mem_req & mem_ack

Behaviour:
- Cache array model: outputs combinational from pins while c_enable=1.
  - cmp=1/write=0: compare-read.
  - cmp=1/write=1: write only on hit; sets dirty.
  - cmp=0/write=0: access-read of tag/data/dirty/valid.
  - cmp=0/write=1: writes tag, data and valid_in; clears dirty.
- Reset (async, any state): state=IDLE, cnt=0; cpu_done, cpu_miss, cpu_rdata=0; all c_* and mem_* outputs 0.
  - Array contents are untouched.
  - mem_req drops immediately and any in-flight beat is abandoned.
- States: IDLE, COMPARE, WB, FILL.
- IDLE:
  - cpu_ready=1; c_enable=0.
  - Edge with cpu_req=1 latches we/addr/wdata and moves to COMPARE; miss_flag cleared.
- COMPARE:
  - c_enable=1, c_cmp=1, c_write=req_we, with latched tag/index/word/wdata.
  - If c_hit: next edge sets cpu_done=1, cpu_rdata=c_data_out (holds previous value on writes), cpu_miss=miss_flag, and returns to IDLE.
  - Hit latency: done is visible in the 2nd cycle after the accept edge. cpu_ready and cpu_done may be high together, and a new request is accepted in that cycle.
  - If miss: set miss_flag, cnt=0. Go to WB if c_valid & c_dirty, else FILL.
- WB:
  - c_enable=1, cmp=0, write=0, c_word=cnt.
  - mem_req=1, mem_we=1, mem_addr={c_tag_out,index,cnt}, mem_wdata=c_data_out; all held stable until mem_ack.
  - On ack: cnt++. Ack at cnt=3 → FILL, cnt=0.
- FILL:
  - mem_req=1, mem_we=0, mem_addr={req_tag,index,cnt}.
  - During an ack cycle: c_enable=1, cmp=0, write=1, word=cnt, c_tag=req_tag, c_data_in=mem_rdata.
  - c_valid_in=1 only on the cnt=3 beat, 0 on beats 0-2, so a partially filled line is never valid.
  - Ack at cnt=3 → COMPARE (retry; guaranteed hit; write retry marks the line dirty).
  - c_enable=0 in non-ack cycles.
- cpu_req is ignored outside IDLE. cpu_done is exactly one cycle per request.
- Reset mid-WB leaves the victim valid and dirty. Reset mid-FILL leaves the line invalid. Both are recovered by the next request.

Test Plan:
- Cold read 0x743 after reset, mem acks every cycle with data 0xA000+offset → reads 0x740..0x743, no mem writes; done with rdata=0xA003, cpu_miss=1.
- Repeat read 0x743 → no mem_req; done in 2nd cycle after accept, rdata=0xA003, cpu_miss=0.
- Write 0xBEEF to 0x741 → hit, miss=0; then read 0x741 → 0xBEEF.
- Read 0x0C0 (tag 0x03, same index) → writes to 0x740..0x743 with data A000, BEEF, A002, A003, then reads 0x0C0..0x0C3; done with miss=1.
- mem_ack delayed 3 cycles per beat → mem_addr/mem_wdata/mem_we stable while waiting; exactly 4 beats per phase.
- Assert rst_n low after 2 FILL beats → mem_req=0 immediately, outputs 0. After release, the same read misses again (c_valid=0) and refetches all 4 words.
